barrel_shifter_pipe: RTL

//  Parametrised, pipelined barrel shifter: successor to the fixed 8-bit rotate-right shifter.

---
 rtl/barrel_shifter_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined barrel shifter with one log2 stage per register.
// Modes: 000 ROR, 001 ROL, 010 SRL, 011 SLL, 100 SRA, others reserved (pass-through, err=1).
// A single global stall freezes every stage whenever the output is valid but not taken.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [2:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_err,
  output logic [$clog2(WIDTH):0]     occupancy
);

  localparam int SHW = $clog2(WIDTH);

  // Stage registers; index k holds the transaction after stage k has applied its 2^k step.
  logic [SHW-1:0]   vld_q;
  logic [SHW-1:0]   err_q;
  logic [WIDTH-1:0] dat_q  [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [2:0]       mode_q [SHW];
  logic             fill_q [SHW];

  // Values each stage will capture on the next un-stalled edge.
  logic [SHW-1:0]   nxt_vld;
  logic [SHW-1:0]   nxt_err;
  logic [WIDTH-1:0] nxt_dat  [SHW];
  logic [SHW-1:0]   nxt_amt  [SHW];
  logic [2:0]       nxt_mode [SHW];
  logic             nxt_fill [SHW];

  logic stall;

  // One fixed-distance step of the selected operation; SRA fills with the
  // operand's original MSB, which travels alongside the data as fill.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [2:0]       mode,
                                                input logic             fill,
                                                input int               sh);
    logic [WIDTH-1:0] fillv;
    logic [WIDTH-1:0] y;
    fillv = {WIDTH{fill}};
    case (mode)
      3'b000:  y = (x >> sh) | (x << (WIDTH - sh));
      3'b001:  y = (x << sh) | (x >> (WIDTH - sh));
      3'b010:  y = x >> sh;
      3'b011:  y = x << sh;
      3'b100:  y = (x >> sh) | (fillv << (WIDTH - sh));
      default: y = x;
    endcase
    return y;
  endfunction

  assign stall    = vld_q[SHW-1] && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             cur_vld;
    logic             cur_err;
    logic             cur_fill;
    logic [WIDTH-1:0] cur_dat;
    logic [SHW-1:0]   cur_amt;
    logic [2:0]       cur_mode;

    if (k == 0) begin : g_first
      assign cur_vld  = in_valid;
      assign cur_err  = (in_mode > 3'd4);
      assign cur_fill = in_data[WIDTH-1];
      assign cur_dat  = in_data;
      assign cur_amt  = in_amt;
      assign cur_mode = in_mode;
    end else begin : g_next
      assign cur_vld  = vld_q[k-1];
      assign cur_err  = err_q[k-1];
      assign cur_fill = fill_q[k-1];
      assign cur_dat  = dat_q[k-1];
      assign cur_amt  = amt_q[k-1];
      assign cur_mode = mode_q[k-1];
    end

    assign nxt_vld[k]  = cur_vld;
    assign nxt_err[k]  = cur_err;
    assign nxt_fill[k] = cur_fill;
    assign nxt_amt[k]  = cur_amt;
    assign nxt_mode[k] = cur_mode;
    assign nxt_dat[k]  = (cur_amt[k] && !cur_err) ?
                         shift_by(cur_dat, cur_mode, cur_fill, 1 << k) : cur_dat;
  end

  // Advance the whole pipeline together unless the output is blocked; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        dat_q[k]  <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
        fill_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      vld_q <= nxt_vld;
      err_q <= nxt_err;
      for (int k = 0; k < SHW; k++) begin
        dat_q[k]  <= nxt_dat[k];
        amt_q[k]  <= nxt_amt[k];
        mode_q[k] <= nxt_mode[k];
        fill_q[k] <= nxt_fill[k];
      end
    end
  end

  // Occupancy is the number of live stages, so it tracks accepts and deliveries automatically.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < SHW; k++) begin
      occupancy = occupancy + {{SHW{1'b0}}, vld_q[k]};
    end
  end

  assign out_valid = vld_q[SHW-1];
  assign out_data  = dat_q[SHW-1];
  assign out_err   = err_q[SHW-1] && vld_q[SHW-1];

endmodule
